uart_tx_arbiter: RTL and testbench

Round-robin controller that shares one UART serial output between N_REQ byte producers.
- Bit timing comes from the bclk output of the team's baud rate generator; that generator must be reset by the same reset.
- Owns framing and sequencing: start bit, 8 data bits LSB-first, optional parity, stop bit.
- Sits between on-chip clients (debug console, bootloader, status reporter) and the uart tx pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rr_arbiter.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and types for the transmit arbiter slice.
package uart_pkg;

    localparam int   UART_DATA_W        = 8;
    localparam logic UART_IDLE_LEVEL    = 1'b1;
    localparam int   UART_FRAME_LEN     = 10;
    localparam int   UART_FRAME_LEN_PAR = 11;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        STOP
    } uart_state_t;

    function automatic logic uart_even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module uart_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_valid
);

    int idx;

    // Walk offsets from the far end back towards ptr so the closest valid wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = |valid;
        idx       = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin UART transmitter sharing one tx line between N_REQ byte producers.
// Define UART_TX_ARB_PARITY_EN to append an even parity bit (11-bit frames).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 8,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bclk,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx,
    output logic                    busy,
    output logic [IDX_W-1:0]        grant_id
);

    if (N_REQ < 2) begin : g_bad_n_req
        $fatal(1, "uart_tx_arbiter: N_REQ must be >= 2");
    end
    if (DATA_W != UART_DATA_W) begin : g_bad_data_w
        $fatal(1, "uart_tx_arbiter: DATA_W must be 8");
    end

    localparam logic [3:0] DATA_DONE = 4'(DATA_W);

    uart_state_t       state;
    logic              bclk_q;
    logic              tick;
    logic              accepting;
    logic              any_valid;
    logic [N_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  next_ptr;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] win_data;
    logic [3:0]        bit_cnt;
`ifdef UART_TX_ARB_PARITY_EN
    logic              parity_q;
`endif

    uart_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (any_valid)
    );

    assign tick      = bclk & ~bclk_q;
    assign accepting = (state == IDLE) || (state == STOP);
    assign req_ready = (tick && accepting && !reset) ? arb_grant : '0;
    assign next_ptr  = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) win_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    // A DATA-state tick with bit_cnt == DATA_DONE drives the stop level and enters
    // STOP; the following tick in STOP closes the frame and may start the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bclk_q   <= 1'b0;
            tx       <= UART_IDLE_LEVEL;
            busy     <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
`ifdef UART_TX_ARB_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            bclk_q <= bclk;
            if (tick) begin
                case (state)
                    IDLE, STOP: begin
                        if (any_valid) begin
                            shift    <= win_data;
                            grant_id <= arb_idx;
                            rr_ptr   <= next_ptr;
                            tx       <= ~UART_IDLE_LEVEL;
                            busy     <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= DATA;
`ifdef UART_TX_ARB_PARITY_EN
                            parity_q <= uart_even_parity(win_data);
`endif
                        end else begin
                            tx    <= UART_IDLE_LEVEL;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    DATA: begin
                        if (bit_cnt == DATA_DONE) begin
                            tx    <= UART_IDLE_LEVEL;
                            state <= STOP;
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
`ifdef UART_TX_ARB_PARITY_EN
                            if (bit_cnt == DATA_DONE - 4'd1) state <= PAR;
`endif
                        end
                    end
`ifdef UART_TX_ARB_PARITY_EN
                    PAR: begin
                        if (bit_cnt == DATA_DONE) begin
                            tx      <= parity_q;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            tx    <= UART_IDLE_LEVEL;
                            state <= STOP;
                        end
                    end
`endif
                    default: begin
                        tx    <= UART_IDLE_LEVEL;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed and random traffic checked
// against a frame-level bit-queue model evaluated once per bit period.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int FLEN = 11;
`else
    localparam int FLEN = 10;
`endif

    typedef struct packed {
        logic         tx;
        logic         busy;
        logic [1:0]   gid;
        logic [N-1:0] rdy;
        logic         glitch;
    } snap_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         bclk;
    logic [N-1:0] req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0] req_ready;
    logic         tx;
    logic         busy;
    logic [1:0]   grant_id;

    int   n_run = 0;
    int   n_fail = 0;
    int   bit_clks = 8;
    int   gen_cnt;
    logic tb_tick;
    logic hold_tx;

    // Reference model: pending requests, rr pointer and the bits still to send.
    logic [7:0] m_data [N];
    logic       m_pend [N];
    int         m_ptr;
    bit         m_bits [$];
    logic       exp_tx;
    logic       exp_busy;
    logic [1:0] exp_gid;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bclk      (bclk),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Baud generator stand-in, reset by the same reset as the DUT.
    initial begin
        logic nb;
        bclk = 1'b0; gen_cnt = 0; tb_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                gen_cnt = 0; bclk = 1'b0; tb_tick = 1'b0;
            end else begin
                gen_cnt = (gen_cnt + 1) % bit_clks;
                nb      = (gen_cnt >= bit_clks / 2);
                tb_tick = nb & ~bclk;
                bclk    = nb;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_reset();
        m_bits.delete();
        m_ptr = 0; exp_tx = 1'b1; exp_busy = 1'b0; exp_gid = 2'd0;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    endfunction

    function automatic void model_tick(output logic [N-1:0] rdy);
        int w;
        w   = -1;
        rdy = '0;
        if (m_bits.size() == 0) begin
            for (int k = 0; k < N; k++)
                if (w < 0 && m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            exp_busy = (w >= 0);
            if (w >= 0) begin
                rdy[w]    = 1'b1;
                m_pend[w] = 1'b0;
                exp_gid   = 2'(w);
                m_ptr     = (w + 1) % N;
                m_bits.push_back(1'b0);
                for (int b = 0; b < 8; b++) m_bits.push_back(m_data[w][b]);
`ifdef UART_TX_ARB_PARITY_EN
                m_bits.push_back(^m_data[w]);
`endif
                m_bits.push_back(1'b1);
            end
        end
        exp_tx = (m_bits.size() > 0) ? m_bits.pop_front() : 1'b1;
    endfunction

    task automatic raise(input int i, input logic [7:0] d);
        req_valid[i] = 1'b1; req_data[i*8 +: 8] = d;
        m_pend[i] = 1'b1; m_data[i] = d;
    endtask

    task automatic lower(input int i);
        req_valid[i] = 1'b0; m_pend[i] = 1'b0;
    endtask

    // Waits for the next bit tick, samples the DUT there, advances the model and
    // retires the accepted request just after the clock edge that transfers it.
    task automatic next_tick(output snap_t obs, output snap_t exp);
        int         budget;
        logic       gl;
        logic [N-1:0] e_rdy;
        budget = 0; gl = 1'b0;
        do begin
            @(negedge clk); #1;
            budget++;
            if (!tb_tick && tx !== hold_tx) gl = 1'b1;
        end while (!tb_tick && budget < 2 * bit_clks + 4);
        if (!tb_tick) gl = 1'b1;
        obs.tx = tx; obs.busy = busy; obs.gid = grant_id; obs.rdy = req_ready; obs.glitch = gl;
        exp.tx = exp_tx; exp.busy = exp_busy; exp.gid = exp_gid; exp.glitch = 1'b0;
        model_tick(e_rdy);
        exp.rdy = e_rdy;
        @(posedge clk); #1;
        req_valid = req_valid & ~e_rdy;
        hold_tx   = tx;
    endtask

    task automatic do_reset(input int clks_per_bit);
        @(negedge clk); #2;
        reset = 1'b1; req_valid = '0; req_data = '0;
        model_reset(); hold_tx = 1'b1; bit_clks = clks_per_bit;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        snap_t o, e;
        @(negedge clk); #2;
        reset = 1'b1; req_valid = '1; req_data = {$urandom, $urandom} ;
        #1;
        n_run++; if (tx !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_run++; if (grant_id !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_gid: got %0d want 0", grant_id); end
        repeat (3) begin
            @(negedge clk); #1;
            n_run++; if (req_ready !== '0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 0000", req_ready); end
        end
        req_valid = '0; model_reset(); hold_tx = 1'b1; bit_clks = 8;
        #1 reset = 1'b0;
        for (int t = 0; t < 3; t++) begin
            next_tick(o, e);
            n_run++; if (o !== e) begin n_fail++; $display("[TB] FAIL reset_idle tick %0d: got %b want %b (tx,busy,gid,rdy,glitch)", t, o, e); end
        end
    endtask

    task automatic test_single();
        snap_t o, e;
        logic [10:0] got_bits, want_bits;
        int ready_cnt;
`ifdef UART_TX_ARB_PARITY_EN
        want_bits = 11'b10101001010;
`else
        want_bits = 11'b01101001010;
`endif
        got_bits = '0; ready_cnt = 0;
        do_reset(434);
        raise(1, 8'hA5);
        for (int t = 0; t < FLEN + 2; t++) begin
            next_tick(o, e);
            n_run++; if (o !== e) begin n_fail++; $display("[TB] FAIL single tick %0d: got %b want %b (tx,busy,gid,rdy,glitch)", t, o, e); end
            if (o.rdy[1] === 1'b1) ready_cnt++;
            if (t >= 1 && t <= FLEN) got_bits[t-1] = o.tx;
        end
        n_run++; if (got_bits !== want_bits) begin n_fail++; $display("[TB] FAIL single_bits: got %b want %b", got_bits, want_bits); end
        n_run++; if (ready_cnt != 1) begin n_fail++; $display("[TB] FAIL single_ready_pulses: got %0d want 1", ready_cnt); end
        n_run++; if (grant_id !== 2'd1) begin n_fail++; $display("[TB] FAIL single_gid: got %0d want 1", grant_id); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_rr_all();
        snap_t o, e;
        int order[$];
        int gticks[$];
        int want_order[5];
        want_order = '{0, 1, 2, 3, 0};
        do_reset(8);
        for (int i = 0; i < N; i++) raise(i, 8'(8'h10 + i));
        for (int t = 0; t <= 5 * FLEN + 1; t++) begin
            next_tick(o, e);
            n_run++; if (o !== e) begin n_fail++; $display("[TB] FAIL rr_all tick %0d: got %b want %b (tx,busy,gid,rdy,glitch)", t, o, e); end
            for (int i = 0; i < N; i++) if (o.rdy[i] === 1'b1) begin order.push_back(i); gticks.push_back(t); end
            if (t == 0 && e.rdy[0]) raise(0, 8'h10);
        end
        n_run++;
        if (order.size() != 5) begin
            n_fail++; $display("[TB] FAIL rr_order_len: got %0d grants want 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (order[k] != want_order[k] || gticks[k] != k * FLEN) begin
                    n_fail++;
                    $display("[TB] FAIL rr_order grant %0d: got id %0d at tick %0d want id %0d at tick %0d", k, order[k], gticks[k], want_order[k], k * FLEN);
                    break;
                end
            end
        end
    endtask

    task automatic test_ptr();
        snap_t o, e;
        int order[$];
        do_reset(8);
        raise(1, 8'($urandom));
        for (int t = 0; t <= 3 * FLEN + 1; t++) begin
            next_tick(o, e);
            n_run++; if (o !== e) begin n_fail++; $display("[TB] FAIL ptr tick %0d: got %b want %b (tx,busy,gid,rdy,glitch)", t, o, e); end
            for (int i = 0; i < N; i++) if (o.rdy[i] === 1'b1) order.push_back(i);
            if (t == 3) begin raise(0, 8'($urandom)); raise(3, 8'($urandom)); end
        end
        n_run++;
        if (order.size() != 3 || order[0] != 1 || order[1] != 3 || order[2] != 0) begin
            n_fail++; $display("[TB] FAIL ptr_order: got %p want 1 3 0", order);
        end
    endtask

    task automatic test_reset_mid();
        snap_t o, e;
        int first;
        do_reset(8);
        raise(2, 8'($urandom));
        for (int t = 0; t <= 5; t++) begin
            next_tick(o, e);
            n_run++; if (o !== e) begin n_fail++; $display("[TB] FAIL reset_mid tick %0d: got %b want %b (tx,busy,gid,rdy,glitch)", t, o, e); end
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || grant_id !== 2'd0) begin
            n_fail++; $display("[TB] FAIL reset_mid_abort: got tx=%b busy=%b gid=%0d want tx=1 busy=0 gid=0", tx, busy, grant_id);
        end
        req_valid = '0; model_reset(); hold_tx = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        raise(1, 8'($urandom)); raise(3, 8'($urandom));
        first = -1;
        for (int t = 0; t < FLEN + 2; t++) begin
            next_tick(o, e);
            n_run++; if (o !== e) begin n_fail++; $display("[TB] FAIL reset_mid_after tick %0d: got %b want %b (tx,busy,gid,rdy,glitch)", t, o, e); end
            for (int i = N - 1; i >= 0; i--) if (first < 0 && o.rdy[i] === 1'b1) first = i;
        end
        n_run++; if (first != 1) begin n_fail++; $display("[TB] FAIL reset_mid_ptr: first grant %0d want 1", first); end
    endtask

    task automatic test_drop();
        snap_t o, e;
        do_reset(8);
        next_tick(o, e);
        n_run++; if (o !== e) begin n_fail++; $display("[TB] FAIL drop_pre: got %b want %b (tx,busy,gid,rdy,glitch)", o, e); end
        @(negedge clk); #2;
        req_valid[2] = 1'b1; req_data[23:16] = 8'h5A;
        repeat (3) begin
            @(negedge clk); #1;
            n_run++;
            if (req_ready !== '0 || tx !== 1'b1) begin
                n_fail++; $display("[TB] FAIL drop_window: got ready=%b tx=%b want ready=0000 tx=1", req_ready, tx);
            end
        end
        #1 req_valid[2] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            next_tick(o, e);
            n_run++; if (o !== e) begin n_fail++; $display("[TB] FAIL drop tick %0d: got %b want %b (tx,busy,gid,rdy,glitch)", t, o, e); end
        end
    endtask

    task automatic test_random();
        snap_t o, e;
        do_reset($urandom_range(6, 12));
        for (int t = 0; t < 300; t++) begin
            next_tick(o, e);
            n_run++; if (o !== e) begin n_fail++; $display("[TB] FAIL random tick %0d: got %b want %b (tx,busy,gid,rdy,glitch)", t, o, e); end
            for (int i = 0; i < N; i++) begin
                if (!m_pend[i] && $urandom_range(0, 5) == 0) raise(i, 8'($urandom));
                else if (m_pend[i] && $urandom_range(0, 19) == 0) lower(i);
            end
        end
    endtask

`ifdef UART_TX_ARB_PARITY_EN
    task automatic test_parity();
        snap_t o, e;
        logic par_a, par_b;
        par_a = 1'bx; par_b = 1'bx;
        do_reset(8);
        raise(0, 8'h07);
        for (int t = 0; t <= 2 * FLEN + 1; t++) begin
            next_tick(o, e);
            n_run++; if (o !== e) begin n_fail++; $display("[TB] FAIL parity tick %0d: got %b want %b (tx,busy,gid,rdy,glitch)", t, o, e); end
            if (t == 3) raise(0, 8'h03);
            if (t == 10) par_a = o.tx;
            if (t == FLEN + 10) par_b = o.tx;
        end
        n_run++; if (par_a !== 1'b1) begin n_fail++; $display("[TB] FAIL parity_07: got %b want 1", par_a); end
        n_run++; if (par_b !== 1'b0) begin n_fail++; $display("[TB] FAIL parity_03: got %b want 0", par_b); end
    endtask
`endif

    initial begin
        req_valid = '0; req_data = '0; hold_tx = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_rr_all();
        test_ptr();
        test_reset_mid();
        test_drop();
        test_random();
`ifdef UART_TX_ARB_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
